// File: rtl/secp256k1_jacobian_to_affine_if.sv
// secp256k1_jacobian_to_affine_if: request/result bundle between the converter and its client.
interface secp256k1_jacobian_to_affine_if;
  logic         start;
  logic [255:0] x_in;
  logic [255:0] y_in;
  logic [255:0] z_in;
  logic [255:0] x_aff;
  logic [255:0] y_aff;
  logic         inf;
  logic         busy;
  logic         done;
  modport master (output start, x_in, y_in, z_in, input x_aff, y_aff, inf, busy, done);
  modport slave  (input start, x_in, y_in, z_in, output x_aff, y_aff, inf, busy, done);
endinterface

// File: rtl/secp256k1_jacobian_to_affine.sv
// secp256k1_jacobian_to_affine: Jacobian (X,Y,Z) to affine via Fermat inversion on one shared mod-p multiplier.
// Optional SECP256K1_J2A_INF_CHECK_EN short-cuts Z == 0 to the point at infinity.
module secp256k1_mul_mod (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] a,
  input  logic [255:0] b,
  output logic         done,
  output logic [255:0] r
);
  localparam logic [256:0] P = {1'b0, 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F};
  localparam logic [32:0]  C = 33'h1_000003D1;
  // 2^256 == C (mod p): fold the high half twice, then one conditional subtract suffices
  function automatic logic [255:0] red(input logic [511:0] t);
    logic [289:0] r1;
    logic [256:0] r2;
    r1 = 290'(t[511:256]) * 290'(C) + 290'(t[255:0]);
    r2 = 257'(r1[289:256]) * 257'(C) + 257'(r1[255:0]);
    red = r2 >= P ? 256'(r2 - P) : r2[255:0];
  endfunction
  logic         done_q, done_d;
  logic [255:0] r_q, r_d;
  always_comb begin
    done_d = start;
    r_d    = start ? red(512'(a) * 512'(b)) : r_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      done_q <= 1'b0;
      r_q    <= '0;
    end else begin
      done_q <= done_d;
      r_q    <= r_d;
    end
  assign done = done_q;
  assign r    = r_q;
endmodule

module secp256k1_jacobian_to_affine (
  input logic                           clk,
  input logic                           rst_n,
  secp256k1_jacobian_to_affine_if.slave bus
);
  localparam logic [255:0] E = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2D;
  localparam logic [2:0] IDLE = 3'd0, SQR = 3'd1, MUL = 3'd2, ZI2 = 3'd3,
                         ZI3 = 3'd4, XA = 3'd5, YA = 3'd6, DONE = 3'd7;
  logic [2:0]   state_q, state_d;
  logic [7:0]   k_q, k_d;
  logic         pend_q, pend_d;
  logic [255:0] x_q, x_d, y_q, y_d, z_q, z_d, acc_q, acc_d;
  logic [255:0] x_aff_q, x_aff_d, y_aff_q, y_aff_d;
  logic         inf_q, inf_d, busy_q, busy_d, done_q, done_d;
  logic         mul_start, mul_done;
  logic [255:0] mul_a, mul_b, mul_r;
  secp256k1_mul_mod u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .done  (mul_done),
    .r     (mul_r)
  );
  // z_q is reused for Z^-2 and acc_q for Z^-3 once the inversion is finished
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    acc_d     = acc_q;
    x_aff_d   = x_aff_q;
    y_aff_d   = y_aff_q;
    inf_d     = inf_q;
    done_d    = 1'b0;
    mul_a     = state_q == XA ? x_q : state_q == YA ? y_q : state_q == ZI3 ? z_q : acc_q;
    mul_b     = (state_q == MUL || state_q == XA) ? z_q : acc_q;
    mul_start = state_q != IDLE && state_q != DONE && !pend_q;
    pend_d    = mul_start | (pend_q & ~mul_done);
    case (state_q)
      IDLE: if (bus.start) begin
        x_d     = bus.x_in;
        y_d     = bus.y_in;
        z_d     = bus.z_in;
        acc_d   = bus.z_in;
        k_d     = 8'd254;
        state_d = SQR;
`ifdef SECP256K1_J2A_INF_CHECK_EN
        state_d = ~|bus.z_in ? DONE : SQR;
`endif
      end
      SQR: if (mul_done) begin
        acc_d   = mul_r;
        state_d = E[k_q] ? MUL : k_q == 8'd0 ? ZI2 : SQR;
        k_d     = (!E[k_q] && k_q != 8'd0) ? k_q - 8'd1 : k_q;
      end
      MUL: if (mul_done) begin
        acc_d   = mul_r;
        state_d = k_q == 8'd0 ? ZI2 : SQR;
        k_d     = k_q == 8'd0 ? k_q : k_q - 8'd1;
      end
      ZI2: if (mul_done) begin
        z_d     = mul_r;
        state_d = ZI3;
      end
      ZI3: if (mul_done) begin
        acc_d   = mul_r;
        state_d = XA;
      end
      XA: if (mul_done) begin
        x_aff_d = mul_r;
        state_d = YA;
      end
      YA: if (mul_done) begin
        y_aff_d = mul_r;
        state_d = DONE;
      end
      default: begin
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef SECP256K1_J2A_INF_CHECK_EN
        inf_d   = ~|z_q;
        x_aff_d = ~|z_q ? '0 : x_aff_q;
        y_aff_d = ~|z_q ? '0 : y_aff_q;
`else
        inf_d   = 1'b0;
`endif
      end
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      pend_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      acc_q   <= '0;
      x_aff_q <= '0;
      y_aff_q <= '0;
      inf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      pend_q  <= pend_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      acc_q   <= acc_d;
      x_aff_q <= x_aff_d;
      y_aff_q <= y_aff_d;
      inf_q   <= inf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  assign bus.x_aff = x_aff_q;
  assign bus.y_aff = y_aff_q;
  assign bus.inf   = inf_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_secp256k1_jacobian_to_affine.sv
// tb_secp256k1_jacobian_to_affine: random and directed conversions checked against a modular-arithmetic model.
module tb_secp256k1_jacobian_to_affine;
  localparam logic [255:0] P  = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] GX = 256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
  localparam logic [255:0] GY = 256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
  localparam int FULL = 507 * 2 + 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  secp256k1_jacobian_to_affine_if bus ();
  secp256k1_jacobian_to_affine dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mm(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t;
    t = (512'(a) * 512'(b)) % 512'(P);
    return t[255:0];
  endfunction

  function automatic logic [255:0] minv(input logic [255:0] z);
    logic [255:0] e, r, s;
    e = P - 256'd2;
    r = 256'd1;
    s = z;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = mm(r, s);
      s = mm(s, s);
    end
    return r;
  endfunction

  function automatic logic [255:0] rnd();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r >= P ? r - P : r;
  endfunction

  task automatic run(input logic [255:0] x, input logic [255:0] y, input logic [255:0] z, input int hit);
    logic [255:0] zi, zi2, ex, ey;
    logic         ei;
    int           el, lat;
    zi  = minv(z);
    zi2 = mm(zi, zi);
    ex  = mm(x, zi2);
    ey  = mm(y, mm(zi2, zi));
    ei  = 1'b0;
    el  = FULL;
`ifdef SECP256K1_J2A_INF_CHECK_EN
    if (z == '0) begin
      ei = 1'b1;
      el = 2;
    end
`endif
    @(negedge clk);
    bus.start = 1'b1;
    bus.x_in  = x;
    bus.y_in  = y;
    bus.z_in  = z;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.x_in  = rnd();
    lat = 1;
    chk("busy_after_start", 256'(bus.busy), 256'd1);
    while (!bus.done && lat < 3000) begin
      bus.start = (lat == hit);
      if (lat == hit) begin
        bus.x_in = rnd();
        bus.y_in = rnd();
        bus.z_in = rnd();
      end
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
    chk("done_seen", 256'(bus.done), 256'd1);
    chk("busy_at_done", 256'(bus.busy), 256'd0);
    chk("latency", 256'(lat), 256'(el));
    chk("x_aff", bus.x_aff, ex);
    chk("y_aff", bus.y_aff, ey);
    chk("inf", 256'(bus.inf), 256'(ei));
  endtask

  initial begin
    logic [255:0] sx;
    int           extra;
    bus.start = 1'b0;
    bus.x_in  = '0;
    bus.y_in  = '0;
    bus.z_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x_aff", bus.x_aff, '0);
    chk("rst_y_aff", bus.y_aff, '0);
    chk("rst_inf", 256'(bus.inf), '0);
    chk("rst_busy", 256'(bus.busy), '0);
    chk("rst_done", 256'(bus.done), '0);
    @(negedge clk);
    rst_n = 1'b1;

    run(GX, GY, 256'd1, -1);
    chk("g_z1_x", bus.x_aff, GX);
    chk("g_z1_y", bus.y_aff, GY);
    run(mm(256'd4, GX), mm(256'd8, GY), 256'd2, -1);
    chk("g_z2_x", bus.x_aff, GX);
    chk("g_z2_y", bus.y_aff, GY);
    run(256'd1, 256'd1, 256'd0, -1);
    chk("z0_x", bus.x_aff, '0);
    chk("z0_y", bus.y_aff, '0);

    run(rnd(), rnd(), rnd(), 100);
    sx = bus.x_aff;
    extra = 0;
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) extra++;
    end
    chk("ignored_start_done_count", 256'(extra), '0);
    chk("ignored_start_x_held", bus.x_aff, sx);

    @(negedge clk);
    bus.start = 1'b1;
    bus.x_in  = rnd();
    bus.y_in  = rnd();
    bus.z_in  = rnd();
    @(negedge clk);
    bus.start = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_x_aff", bus.x_aff, '0);
    chk("midrst_y_aff", bus.y_aff, '0);
    chk("midrst_busy", 256'(bus.busy), '0);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) extra++;
    end
    chk("midrst_no_done", 256'(extra), '0);
    @(negedge clk);
    rst_n = 1'b1;
    run(GX, GY, 256'd1, -1);
    chk("after_rst_x", bus.x_aff, GX);
    chk("after_rst_y", bus.y_aff, GY);

    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      run(rnd(), rnd(), rnd(), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
